hazard_forward_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage PA-RISC core (IF, ID, EX, MEM, WB).
- Keeps its own shadow copy of destination info for the EX, MEM and WB stages.
- From that it drives the ID-stage forwarding selects (A_S/B_S), the load-use stall (IF/ID LE plus the CU-mux NOP select) and the IF PC-mux select on a taken branch.
- Also counts stall cycles for debug.

---
 rtl/hazard_forward_ctrl_if.sv | 34 +++
 rtl/hazard_forward_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_forward_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hazard_forward_ctrl_if.sv
// Bundles the ID-stage operand/CU info, EX branch flag and the controller's selects.
// Purely wiring; no latency of its own.
// No handshake: the pipeline consumes LE/NOP_S every cycle.
interface hazard_forward_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ID_RA;
  logic [REG_W-1:0] ID_RB;
  logic             ID_USE_A;
  logic             ID_USE_B;
  logic [REG_W-1:0] ID_RD;
  logic             ID_RF_LE;
  logic             ID_L;
  logic             EX_J;
  logic [1:0]       A_S;
  logic [1:0]       B_S;
  logic             LE;
  logic             NOP_S;
  logic             PC_S;
  logic [CNT_W-1:0] STALL_CNT;

  // Pipeline side: presents the ID/EX information, consumes the selects.
  modport master (
    output ID_RA, ID_RB, ID_USE_A, ID_USE_B, ID_RD, ID_RF_LE, ID_L, EX_J,
    input  A_S, B_S, LE, NOP_S, PC_S, STALL_CNT
  );

  // Controller side.
  modport slave (
    input  ID_RA, ID_RB, ID_USE_A, ID_USE_B, ID_RD, ID_RF_LE, ID_L, EX_J,
    output A_S, B_S, LE, NOP_S, PC_S, STALL_CNT
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage core, tracking EX/MEM/WB dest info.
// Selects, stall and PC select are combinational (0 cycles); shadow advances in 1 cycle.
// Load-use hazard drops LE and inserts a one-cycle bubble; never stalls longer per load.
module hazard_forward_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  hazard_forward_ctrl_if.slave bus
);

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             rf_le;
    logic             l;
  } sh_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  sh_t              sh_ex, sh_mem, sh_wb;
  state_t           state_q, state_d;
  logic             le, nop_s;
  logic [CNT_W-1:0] stall_cnt;
  logic             ex_hit_a, ex_hit_b, hz;

  // A stage supplies an operand only if it writes the RF, targets that register,
  // the ID instruction really reads it, and it is not GR0 (hard-wired zero).
  function automatic logic hit(input sh_t s, input logic use_r, input logic [REG_W-1:0] rs);
    return use_r && s.rf_le && (s.rd == rs) && (rs != '0);
  endfunction

  // Youngest producer wins so the consumer sees the most recent value.
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [REG_W-1:0] rs);
    if (hit(sh_ex, use_r, rs))       return 2'b01;
    else if (hit(sh_mem, use_r, rs)) return 2'b10;
    else if (hit(sh_wb, use_r, rs))  return 2'b11;
    else                             return 2'b00;
  endfunction

  assign ex_hit_a = hit(sh_ex, bus.ID_USE_A, bus.ID_RA);
  assign ex_hit_b = hit(sh_ex, bus.ID_USE_B, bus.ID_RB);
  // A load in EX has no data yet; a consumer right behind it must wait one cycle.
  assign hz       = sh_ex.l && sh_ex.rf_le && (ex_hit_a || ex_hit_b);

  // Shadow pipeline: bubble enters EX whenever the CU outputs are forced to NOP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh_ex  <= '0;
      sh_mem <= '0;
      sh_wb  <= '0;
    end else begin
      sh_wb  <= sh_mem;
      sh_mem <= sh_ex;
      sh_ex  <= nop_s ? sh_t'('0) : sh_t'({bus.ID_RD, bus.ID_RF_LE, bus.ID_L});
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Next state and stall outputs; a hazard seen in STALL (back-to-back load) stalls again.
  always_comb begin
    state_d = state_q;
    le      = 1'b1;
    nop_s   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz) begin
          le      = 1'b0;
          nop_s   = 1'b1;
          state_d = STALL;
        end
      end
      STALL: begin
        if (hz) begin
          le      = 1'b0;
          nop_s   = 1'b1;
          state_d = STALL;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Debug counter of bubble cycles, saturating so a long run never reads back small.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                     stall_cnt <= '0;
    else if (nop_s && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
  end

  // Shadow is zero during reset so LE/NOP_S/selects settle to idle on their own;
  // PC_S follows the external branch flag and therefore needs explicit gating.
  assign bus.A_S       = fwd_sel(bus.ID_USE_A, bus.ID_RA);
  assign bus.B_S       = fwd_sel(bus.ID_USE_B, bus.ID_RB);
  assign bus.LE        = le;
  assign bus.NOP_S     = nop_s;
  assign bus.PC_S      = RST && bus.EX_J;
  assign bus.STALL_CNT = stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench: a cycle-by-cycle vector table plus reset/saturation sequences.
// Two instances share stimulus: 16-bit counter and a 2-bit counter for saturation.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_hazard_forward_ctrl;

  logic CLK;
  logic RST;

  logic [4:0] ra, rb, rd;
  logic       ua, ub, rfle, ld, exj;

  hazard_forward_ctrl_if #(.REG_W(5), .CNT_W(16)) bus_w();
  hazard_forward_ctrl_if #(.REG_W(5), .CNT_W(2))  bus_s();

  hazard_forward_ctrl #(.CNT_W(16), .REG_W(5)) dut_w (.CLK(CLK), .RST(RST), .bus(bus_w));
  hazard_forward_ctrl #(.CNT_W(2),  .REG_W(5)) dut_s (.CLK(CLK), .RST(RST), .bus(bus_s));

  assign bus_w.ID_RA = ra;   assign bus_s.ID_RA = ra;
  assign bus_w.ID_RB = rb;   assign bus_s.ID_RB = rb;
  assign bus_w.ID_USE_A = ua; assign bus_s.ID_USE_A = ua;
  assign bus_w.ID_USE_B = ub; assign bus_s.ID_USE_B = ub;
  assign bus_w.ID_RD = rd;   assign bus_s.ID_RD = rd;
  assign bus_w.ID_RF_LE = rfle; assign bus_s.ID_RF_LE = rfle;
  assign bus_w.ID_L = ld;    assign bus_s.ID_L = ld;
  assign bus_w.EX_J = exj;   assign bus_s.EX_J = exj;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] ra, rb, rd;
    logic       ua, ub, rfle, l, exj;
    logic [1:0] a_s, b_s;
    logic       le, nop, pc;
    int         cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(int a, int b, int u_a, int u_b, int d, int w, int l, int j,
                              int as, int bs, int le, int nop, int pc, int cnt);
    vec_t v;
    v.ra = 5'(a); v.rb = 5'(b); v.ua = 1'(u_a); v.ub = 1'(u_b);
    v.rd = 5'(d); v.rfle = 1'(w); v.l = 1'(l); v.exj = 1'(j);
    v.a_s = 2'(as); v.b_s = 2'(bs); v.le = 1'(le); v.nop = 1'(nop); v.pc = 1'(pc);
    v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic u_a, input logic u_b,
                       input logic [4:0] d, input logic w, input logic l, input logic j);
    ra = a; rb = b; ua = u_a; ub = u_b; rd = d; rfle = w; ld = l; exj = j;
  endtask

  // Compares {A_S,B_S,LE,NOP_S,PC_S} and both counters against expectations.
  task automatic chk(input string name, input logic [1:0] as, input logic [1:0] bs,
                     input logic le, input logic nop, input logic pc, input int cnt);
    logic [24:0] act, exp;
    int c2;
    c2  = (cnt > 3) ? 3 : cnt;
    act = {bus_w.A_S, bus_w.B_S, bus_w.LE, bus_w.NOP_S, bus_w.PC_S, bus_w.STALL_CNT, bus_s.STALL_CNT};
    exp = {as, bs, le, nop, pc, 16'(cnt), 2'(c2)};
    // Both instances must agree on the selects as well.
    act = act | {bus_s.A_S ^ bus_w.A_S, bus_s.B_S ^ bus_w.B_S, bus_s.LE ^ bus_w.LE,
                 bus_s.NOP_S ^ bus_w.NOP_S, bus_s.PC_S ^ bus_w.PC_S, 18'd0};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got{A_S,B_S,LE,NOP_S,PC_S,CNT16,CNT2}=%h want=%h", name, act, exp);
    end
  endtask

  initial begin
    // ra rb ua ub rd rfle l exj | a_s b_s le nop pc cnt
    tbl[0]  = mk( 1, 2,1,1, 5,1,0,0, 0,0,1,0,0,0);
    tbl[1]  = mk( 1, 2,1,1, 5,1,0,0, 0,0,1,0,0,0);
    tbl[2]  = mk( 1, 2,1,1, 5,1,0,0, 0,0,1,0,0,0);
    tbl[3]  = mk( 5, 0,1,1, 9,1,0,0, 1,0,1,0,0,0);
    tbl[4]  = mk( 5, 6,1,0, 0,0,0,0, 2,0,1,0,0,0);
    tbl[5]  = mk( 5, 6,1,0, 0,0,0,0, 3,0,1,0,0,0);
    tbl[6]  = mk( 5, 9,1,1, 0,1,0,0, 0,3,1,0,0,0);
    tbl[7]  = mk( 0, 0,1,1, 0,1,0,0, 0,0,1,0,0,0);
    tbl[8]  = mk( 1, 1,1,1,12,1,0,0, 0,0,1,0,0,0);
    tbl[9]  = mk(12,12,0,1, 0,0,0,0, 0,1,1,0,0,0);
    tbl[10] = mk( 1, 0,1,0, 7,1,1,0, 0,0,1,0,0,0);
    tbl[11] = mk( 2, 7,1,1, 8,1,0,0, 0,1,0,1,0,0);
    tbl[12] = mk( 2, 7,1,1, 8,1,0,0, 0,2,1,0,0,1);
    tbl[13] = mk( 8, 7,1,1, 0,0,0,0, 1,3,1,0,0,1);
    tbl[14] = mk( 0, 0,0,0, 3,1,1,0, 0,0,1,0,0,1);
    tbl[15] = mk( 3, 0,1,0, 4,1,1,0, 1,0,0,1,0,1);
    tbl[16] = mk( 3, 0,1,0, 4,1,1,0, 2,0,1,0,0,2);
    tbl[17] = mk( 0, 4,0,1,10,1,0,0, 0,1,0,1,0,2);
    tbl[18] = mk( 0, 4,0,1,10,1,0,0, 0,2,1,0,0,3);
    tbl[19] = mk(10, 4,1,1, 0,0,0,0, 1,3,1,0,0,3);
    tbl[20] = mk( 0, 0,0,0,11,1,0,1, 0,0,1,0,1,3);
    tbl[21] = mk(11,10,1,1, 0,0,0,0, 1,3,1,0,0,3);
    tbl[22] = mk( 0, 0,0,0,13,1,1,0, 0,0,1,0,0,3);
    tbl[23] = mk(13, 0,1,0, 0,0,0,1, 1,0,0,1,1,3);
    tbl[24] = mk(13, 0,1,0, 0,0,0,0, 2,0,1,0,0,4);

    // Reset held for three cycles with random inputs.
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      #1 chk($sformatf("reset_c%0d", i), 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0);
    end
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;

    // Vector table, one row per clock.
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(tbl[i].ra, tbl[i].rb, tbl[i].ua, tbl[i].ub, tbl[i].rd, tbl[i].rfle, tbl[i].l, tbl[i].exj);
      #1 chk($sformatf("row%0d", i), tbl[i].a_s, tbl[i].b_s, tbl[i].le, tbl[i].nop, tbl[i].pc, tbl[i].cnt);
    end

    // Fifth stall: the 2-bit counter must stay at 3.
    @(negedge CLK); drive(0, 0, 0, 0, 7, 1, 1, 0);
    @(negedge CLK); drive(7, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("stall5", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 4);
    @(negedge CLK);
    #1 chk("sat_hold", 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 5);

    // Sixth stall interrupted by an asynchronous reset between clock edges.
    @(negedge CLK); drive(0, 0, 0, 0, 7, 1, 1, 0);
    @(negedge CLK); drive(7, 0, 1, 0, 0, 0, 0, 1);
    #1 chk("stall6", 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 5);
    #1 RST = 1'b0;
    #1 chk("async_rst", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0);
    @(negedge CLK);
    #2 RST = 1'b1;
    drive(0, 0, 0, 0, 7, 1, 1, 0);
    #1 chk("post_rst", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0);
    @(negedge CLK); drive(0, 7, 0, 1, 0, 0, 0, 0);
    #1 chk("post_rst_hz", 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 0);
    @(negedge CLK);
    #1 chk("post_rst_fwd", 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
